// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: one word per accepted start, per-transfer mode,
// bit order and sclk divider; sclk, cs_n and mosi all come straight from flops.
module spi_master_mc #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data
);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [EDGE_W-1:0] edge_nxt;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              sample;
    logic              advance;

    // Out-of-range indices match no bit, so every select stays high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        for (int i = 0; i < NUM_CS; i++) begin
            v[i] = (sel != CS_W'(i));
        end
        return v;
    endfunction

    // Edges are numbered 1..2*DATA_W; odd edges are the leading ones.
    assign edge_nxt = edge_cnt_q + 1'b1;
    assign sample   = cpha_q ? ~edge_nxt[0] : edge_nxt[0];
    assign advance  = cpha_q ? edge_nxt[0] : (~edge_nxt[0] && (edge_nxt != LAST_EDGE));

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        cs_n_d     = cs_n_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETUP;
                    div_d      = clk_div;
                    cnt_d      = clk_div;
                    edge_cnt_d = '0;
                    cpol_d     = mode[1];
                    cpha_d     = mode[0];
                    lsb_d      = lsb_first;
                    sclk_d     = mode[1];
                    busy_d     = 1'b1;
                    cs_n_d     = cs_decode(cs_sel);
                    rx_sh_d    = '0;
                    if (!mode[0]) begin
                        mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                        tx_sh_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
                    end else begin
                        mosi_d  = 1'b0;
                        tx_sh_d = tx_data;
                    end
                end
            end
            SETUP, XFER, HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                    sclk_d  = cpol_q;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = div_q;
                    if (state_q == HOLD) begin
                        state_d    = DONE;
                        cs_n_d     = '1;
                        mosi_d     = 1'b0;
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        sclk_d     = ~sclk_q;
                        edge_cnt_d = edge_nxt;
                        state_d    = (edge_nxt == LAST_EDGE) ? HOLD : XFER;
                        if (sample) begin
                            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]}
                                            : {rx_sh_q[DATA_W-2:0], miso};
                        end
                        if (advance) begin
                            mosi_d  = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
                            tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = '1;
                busy_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign mosi     = mosi_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: a cycle-sampled SPI slave model plus
// hand-computed expectations for timing, data, abort, reset and back-to-back use.
module tb_spi_master_mc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] cs_sel = 2'd0;
    logic [1:0] mode = 2'd0;
    logic       lsb_first = 1'b0;
    logic [7:0] clk_div = 8'd0;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic [3:0] cs_n;
    logic       busy;
    logic       rx_valid;
    logic [7:0] rx_data;

    int tests = 0;
    int fails = 0;

    // Slave model configuration and state
    int         slv_cs = 0;
    logic       slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lsb = 1'b0, slv_loop = 1'b0;
    logic       slv_on = 1'b0, slv_prev = 1'b0, slv_miso = 1'b0;
    logic [7:0] slv_tx = 8'h00, slv_sh = 8'h00, slv_rx = 8'h00;

    spi_master_mc #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .tx_data(tx_data), .cs_sel(cs_sel), .mode(mode), .lsb_first(lsb_first),
        .clk_div(clk_div), .miso(miso), .mosi(mosi), .sclk(sclk), .cs_n(cs_n),
        .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    assign miso = slv_loop ? mosi : slv_miso;

    // Slave reacts to sclk transitions seen at the falling clk edge.
    always @(negedge clk) begin
        if (cs_n[slv_cs] == 1'b0) begin
            if (!slv_on) begin
                slv_on   = 1'b1;
                slv_prev = sclk;
                slv_sh   = slv_tx;
                slv_rx   = 8'h00;
                if (!slv_cpha) begin
                    slv_miso = slv_lsb ? slv_sh[0] : slv_sh[7];
                    slv_sh   = slv_lsb ? (slv_sh >> 1) : (slv_sh << 1);
                end
            end else if (sclk !== slv_prev) begin
                slv_prev = sclk;
                if ((sclk != slv_cpol) ^ slv_cpha) begin
                    slv_rx = slv_lsb ? {mosi, slv_rx[7:1]} : {slv_rx[6:0], mosi};
                end else begin
                    slv_miso = slv_lsb ? slv_sh[0] : slv_sh[7];
                    slv_sh   = slv_lsb ? (slv_sh >> 1) : (slv_sh << 1);
                end
            end
        end else begin
            slv_on = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_xfer(input string tag, input logic [7:0] tx, input int cs,
                           input logic [1:0] md, input logic lsb, input logic [7:0] div,
                           input logic [7:0] stx, input logic loopb, input logic with_abort,
                           input logic [7:0] exp_rx);
        int         h, n, edges, bad, done_n;
        logic       prev;
        logic [3:0] mask;
        h = int'(div) + 1;
        slv_cs = cs; slv_cpol = md[1]; slv_cpha = md[0]; slv_lsb = lsb;
        slv_tx = stx; slv_loop = loopb;
        @(posedge clk); #1;
        start = 1'b1; abort = with_abort; tx_data = tx; cs_sel = 2'(cs);
        mode = md; lsb_first = lsb; clk_div = div;
        @(posedge clk); #1;
        // Scramble inputs after acceptance: the transfer must use latched values.
        start = 1'b0; abort = 1'b0; tx_data = ~tx; cs_sel = 2'(cs + 1);
        mode = ~md; lsb_first = ~lsb; clk_div = div + 8'd3;
        edges = 0; bad = 0; done_n = 0; prev = md[1]; mask = 4'h0; n = 1;
        while (n <= 2000 && done_n == 0) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, " busy_setup"}, busy, 1);
                check({tag, " sclk_idle"}, sclk, md[1]);
                if (!md[0]) check({tag, " first_mosi"}, mosi, lsb ? tx[0] : tx[7]);
            end
            if (sclk !== prev) begin
                edges++;
                if (n != 1 + edges * h) bad++;
                prev = sclk;
            end
            mask |= ~cs_n;
            if (rx_valid === 1'b1) done_n = n;
            n++;
        end
        check({tag, " done_cycle"}, done_n, 1 + 17 * h);
        check({tag, " edge_count"}, edges, 16);
        check({tag, " edge_timing_errs"}, bad, 0);
        check({tag, " rx_data"}, rx_data, exp_rx);
        check({tag, " busy_done"}, busy, 1);
        check({tag, " mosi_done"}, mosi, 0);
        check({tag, " cs_n_done"}, cs_n, 4'hF);
        check({tag, " cs_mask"}, mask, 1 << cs);
        check({tag, " slave_rx"}, slv_rx, tx);
        @(negedge clk);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " rx_valid_after"}, rx_valid, 0);
        check({tag, " rx_hold"}, rx_data, exp_rx);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges, pulses, gaps, bad_gap, bad_low, bad_rx, run, cnt;
        logic prev, prev_cs;

        #12;
        check("reset cs_n", cs_n, 4'hF);
        check("reset sclk", sclk, 0);
        check("reset mosi", mosi, 0);
        check("reset busy", busy, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_xfer("mode0", 8'hA5, 2, 2'b00, 1'b0, 8'd1, 8'h3C, 1'b0, 1'b0, 8'h3C);

        // Abort on edge 5; previous rx_data must survive.
        slv_cs = 2; slv_cpol = 1'b0; slv_cpha = 1'b0; slv_lsb = 1'b0;
        slv_tx = 8'hFF; slv_loop = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; tx_data = 8'hF0; cs_sel = 2'd2; mode = 2'b00; lsb_first = 1'b0; clk_div = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; prev = 1'b0; cnt = 0;
        while (cnt < 200 && edges < 5) begin
            @(negedge clk);
            if (sclk !== prev) begin edges++; prev = sclk; end
            cnt++;
        end
        check("abort reached_edge5", edges, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort cs_n", cs_n, 4'hF);
        check("abort busy", busy, 0);
        check("abort sclk", sclk, 0);
        check("abort mosi", mosi, 0);
        check("abort rx_data", rx_data, 8'h3C);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) pulses++;
        end
        check("abort no_rx_valid", pulses, 0);
        check("abort still_idle", busy, 0);

        do_xfer("mode1", 8'h5A, 1, 2'b01, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 8'h5A);
        do_xfer("mode2", 8'h5A, 0, 2'b10, 1'b0, 8'd2, 8'h00, 1'b1, 1'b0, 8'h5A);
        do_xfer("mode3", 8'h5A, 3, 2'b11, 1'b0, 8'd3, 8'h00, 1'b1, 1'b0, 8'h5A);
        do_xfer("lsb", 8'h01, 2, 2'b00, 1'b1, 8'd1, 8'h80, 1'b0, 1'b0, 8'h80);
        do_xfer("abort_start", 8'h69, 3, 2'b01, 1'b0, 8'd1, 8'h00, 1'b1, 1'b1, 8'h69);

        // Reset mid-transfer in mode 3 (sclk idling high).
        slv_cs = 1; slv_cpol = 1'b1; slv_cpha = 1'b1; slv_loop = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; tx_data = 8'h77; cs_sel = 2'd1; mode = 2'b11; clk_div = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst cs_n", cs_n, 4'hF);
        check("rst sclk", sclk, 0);
        check("rst mosi", mosi, 0);
        check("rst busy", busy, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_xfer("post_rst", 8'hC3, 0, 2'b00, 1'b0, 8'd0, 8'h96, 1'b0, 1'b0, 8'h96);

        // Start held high with H=1: 17 cycles selected, 2 deselected between words.
        slv_cs = 1; slv_cpol = 1'b0; slv_cpha = 1'b0; slv_lsb = 1'b0; slv_loop = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; tx_data = 8'h3C; cs_sel = 2'd1; mode = 2'b00; lsb_first = 1'b0; clk_div = 8'd0;
        pulses = 0; gaps = 0; bad_gap = 0; bad_low = 0; bad_rx = 0; run = 0; prev_cs = 1'b1; cnt = 0;
        while (cnt < 300 && pulses < 3) begin
            @(negedge clk);
            if (cs_n[1] !== prev_cs) begin
                if (prev_cs == 1'b0) begin
                    if (run != 17) bad_low++;
                end else if (pulses > 0) begin
                    gaps++;
                    if (run != 2) bad_gap++;
                end
                run = 0;
                prev_cs = cs_n[1];
            end
            run++;
            if (rx_valid === 1'b1) begin
                pulses++;
                if (rx_data !== 8'h3C) bad_rx++;
            end
            cnt++;
        end
        start = 1'b0;
        check("b2b pulses", pulses, 3);
        check("b2b gaps", gaps, 2);
        check("b2b gap_len_errs", bad_gap, 0);
        check("b2b low_len_errs", bad_low, 0);
        check("b2b rx_errs", bad_rx, 0);
        repeat (2) @(negedge clk);
        check("b2b stopped", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
